fsk_phase_ctrl: RTL and testbench
=================================

FSK_PHASE_CTRL -- requirements
Module: fsk_phase_ctrl

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 64: sample ticks per data bit; legal range 2..1024.
REQ-002 Parameter INC_SPACE, default 6: phase step per tick, in table entries (1 entry = 1 degree), for bit 0; legal range 1..179.
REQ-003 Parameter INC_MARK, default 12: phase step per tick for bit 1; legal range 1..179.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 sample_tick  in  1  one-cycle strobe that advances one output sample.
REQ-007 din  in  8  byte to transmit, sent LSB first.
REQ-008 din_valid  in  1  din is valid.
REQ-009 din_ready  out  1  byte accepted on any edge where din_valid && din_ready.
REQ-010 lut_addr  out  9  registered phase address to the 3-clock sine LUT; range 0..359.
REQ-011 lut_q  in  12  signed sample returned by the LUT.
REQ-012 dout  out  12  registered signed FSK sample.
REQ-013 dout_valid  out  1  one-cycle strobe marking each new dout.
REQ-014 busy  out  1  high in SEND or while any sample is still in the LUT pipeline.

Function
REQ-015 FSM states: IDLE and SEND; the reset state is IDLE.
REQ-016 IDLE: din_ready = 1; on accept, capture din into shift register, clear bit_cnt (3 bits) and samp_cnt, go to SEND.
REQ-017 SEND, edge with sample_tick = 1: lut_addr <= phase; phase <= phase + inc (inc = INC_MARK if shift[0] else INC_SPACE); samp_cnt increments.
REQ-018 Phase wrap: if phase + inc >= 360, store phase + inc - 360; phase never leaves 0..359 and addresses 360..511 are never driven.
REQ-019 Phase is continuous across bits, bytes and IDLE; it is only cleared by reset.
REQ-020 When samp_cnt = SAMPLES_PER_BIT-1 on a tick: samp_cnt <= 0, shift right one, bit_cnt increments.
REQ-021 Last tick of bit 7: din_ready = 1 combinationally in that cycle only.
REQ-022 On that last tick, if din_valid = 1: load the new byte and stay in SEND with no gap tick; otherwise go to IDLE.
REQ-023 sample_tick in IDLE: no phase advance, no lut_addr change, no dout_valid.
REQ-024 sample_tick = 0 in SEND: all counters, phase and lut_addr hold.
REQ-025 din_valid in SEND outside the REQ-021 cycle: ignored; din_ready = 0.
REQ-026 Valid pipeline: a 4-stage delay of the SEND tick. For a tick at edge t, dout <= lut_q at edge t+4, and dout_valid is high for the cycle after edge t+4 only.
REQ-027 dout holds its value between strobes.
REQ-028 busy = (state == SEND) OR any valid-pipeline stage set.

Reset
REQ-029 rst_n low: state IDLE, phase 0, lut_addr 0, dout 0, dout_valid 0, counters 0, shift register 0, valid pipeline cleared.
REQ-030 Assertion mid-byte aborts the byte with no further dout_valid.
REQ-031 First accept is possible on the first edge after rst_n rises.

Verification
REQ-032 SAMPLES_PER_BIT=4, defaults, tick every cycle, byte 0x01 -> lut_addr 0,12,24,36 then 48,54,60,66,... Expect 32 dout_valid pulses. First two dout are 12'h000 and 12'h1aa (addr 12).
REQ-033 Byte 0xFF, SAMPLES_PER_BIT=64, INC_MARK=12 -> tick 30 presents addr 348, tick 31 presents addr 0 (wrap). There are no addresses >= 360.
REQ-034 Two bytes with din_valid held high, tick every cycle -> din_ready pulses exactly once, on the last tick of byte 1. dout_valid is continuous with no gap, and busy stays 1.
REQ-035 Tick every 5th cycle -> each dout_valid arrives exactly 4 clocks after its tick. Non-tick cycles change nothing; the pipeline latency is unaffected.
REQ-036 rst_n pulsed low at bit 3 of a byte -> all outputs are 0 asynchronously, no stale dout_valid appears afterward, and phase restarts at 0 on the next byte.
REQ-037 Ticks in IDLE, and din_valid during SEND (not the last tick) -> lut_addr and phase are unchanged. The byte is not accepted until REQ-021.

Source files
------------

// File: rtl/fsk_phase_ctrl.sv
// Continuous-phase FSK modulator: serialises bytes LSB first into phase
// addresses for an external 3-clock sine LUT and re-times the returned samples.
module fsk_phase_ctrl #(
    parameter int SAMPLES_PER_BIT = 64,
    parameter int INC_SPACE       = 6,
    parameter int INC_MARK        = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [8:0]  lut_addr,
    input  logic [11:0] lut_q,
    output logic [11:0] dout,
    output logic        dout_valid,
    output logic        busy
);

    localparam int SW = $clog2(SAMPLES_PER_BIT);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [9:0] INC_M = 10'(INC_MARK);
    localparam logic [9:0] INC_S = 10'(INC_SPACE);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, state_nx;

    logic [8:0]    phase;
    logic [8:0]    phase_nx;
    logic [9:0]    phase_sum;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [SW-1:0] samp_cnt;
    logic [3:0]    vpipe;
    logic          adv;
    logic          bit_end;
    logic          last_tick;
    logic          load;

    always_comb begin
        adv       = (state == SEND) && sample_tick;
        bit_end   = adv && (samp_cnt == SAMP_LAST);
        last_tick = bit_end && (bit_cnt == 3'd7);
        din_ready = (state == IDLE) || last_tick;
        load      = din_valid && din_ready;
        phase_sum = {1'b0, phase} + (shift[0] ? INC_M : INC_S);
        phase_nx  = phase_sum[8:0];
        if (phase_sum >= 10'd360) begin
            phase_nx = 9'(phase_sum - 10'd360);
        end
        state_nx = state;
        if (load) begin
            state_nx = SEND;
        end else if (last_tick) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            lut_addr   <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            samp_cnt   <= '0;
            vpipe      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            // vpipe[3] lines up with the sample the LUT returns for that tick
            vpipe      <= {vpipe[2:0], adv};
            dout_valid <= vpipe[3];
            if (vpipe[3]) begin
                dout <= lut_q;
            end
            if (adv) begin
                lut_addr <= phase;
                phase    <= phase_nx;
            end
            if (load) begin
                shift    <= din;
                bit_cnt  <= '0;
                samp_cnt <= '0;
            end else if (bit_end) begin
                shift    <= shift >> 1;
                bit_cnt  <= bit_cnt + 3'd1;
                samp_cnt <= '0;
            end else if (adv) begin
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == SEND) || (|vpipe);

endmodule

// File: tb/tb_fsk_phase_ctrl.sv
// Randomised bench for fsk_phase_ctrl against a byte/tick-level reference model
// and a behavioural 3-clock sine LUT.
module tb_fsk_phase_ctrl;

    localparam int SPB   = 4;
    localparam int INC_S = 6;
    localparam int INC_M = 12;
    localparam int NT    = 8 * SPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [8:0]  lut_addr;
    logic [11:0] lut_q;
    logic [11:0] dout;
    logic        dout_valid;
    logic        busy;

    always #5 clk = ~clk;

    fsk_phase_ctrl #(
        .SAMPLES_PER_BIT(SPB),
        .INC_SPACE(INC_S),
        .INC_MARK(INC_M)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_tick(sample_tick),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .lut_addr(lut_addr),
        .lut_q(lut_q),
        .dout(dout),
        .dout_valid(dout_valid),
        .busy(busy)
    );

    logic [11:0] tbl [0:359];
    logic [11:0] l1 = '0, l2 = '0, l3 = '0;

    initial begin
        for (int i = 0; i < 360; i++) begin
            real x;
            x = 2047.0 * $sin(i * 3.14159265358979 / 180.0);
            tbl[i] = 12'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
        end
    end

    always @(posedge clk) begin
        l1 <= tbl[lut_addr];
        l2 <= l1;
        l3 <= l2;
    end
    assign lut_q = l3;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    bit          m_act = 0;
    logic [7:0]  m_byte = '0;
    int          m_idx = 0;
    int          m_phase = 0;
    int          m_addr = 0;
    logic [11:0] m_dout = '0;
    bit          m_dv = 0;
    int          q_due[$];
    int          q_adr[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_byte = '0; m_idx = 0;
            m_phase = 0; m_addr = 0; m_dout = '0; m_dv = 0;
            q_due.delete(); q_adr.delete();
        end else begin
            cyc++;
            m_dv = 0;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                m_dout = tbl[q_adr[0]];
                m_dv = 1;
                void'(q_due.pop_front());
                void'(q_adr.pop_front());
            end
            if (!m_act) begin
                if (din_valid) begin
                    m_act = 1; m_byte = din; m_idx = 0;
                end
            end else if (sample_tick) begin
                m_addr = m_phase;
                m_phase = (m_phase + (m_byte[m_idx / SPB] ? INC_M : INC_S)) % 360;
                q_due.push_back(cyc + 4);
                q_adr.push_back(m_addr);
                if (m_idx == NT - 1) begin
                    if (din_valid) begin
                        m_byte = din; m_idx = 0;
                    end else begin
                        m_act = 0;
                    end
                end else begin
                    m_idx++;
                end
            end
        end
    end

    int          dv_cnt = 0, rdy_cnt = 0, first_dv = 0, last_dv = 0;
    logic [11:0] d0 = '0, d1 = '0;

    task automatic clear_stats();
        dv_cnt = 0; rdy_cnt = 0; first_dv = 0; last_dv = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("lut_addr", lut_addr, m_addr);
            check("addr_range", int'(lut_addr < 9'd360), 1);
            check("dout", dout, m_dout);
            check("dout_valid", dout_valid, m_dv);
            check("busy", busy, int'(m_act || q_due.size() > 0));
            check("din_ready", din_ready,
                  int'(!m_act || (sample_tick && m_idx == NT - 1)));
            if (dout_valid) begin
                if (dv_cnt == 0) begin d0 = dout; first_dv = cyc; end
                if (dv_cnt == 1) d1 = dout;
                dv_cnt++;
                last_dv = cyc;
            end
            if (din_ready) rdy_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_addr", lut_addr, 0);
        check("rst_dout", dout, 0);
        check("rst_dv", dout_valid, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_addr", lut_addr, 0);
        check("rst_dout", dout, 0);
        check("rst_dv", dout_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // 0x01, tick every cycle: first accept right after reset release
        din = 8'h01; din_valid = 1'b1; sample_tick = 1'b1;
        step();
        din_valid = 1'b0;
        clear_stats();
        repeat (45) step();
        check("a_dv_cnt", dv_cnt, 32);
        check("a_dout0", d0, 12'h000);
        check("a_dout1", d1, 12'h1aa);

        // two back-to-back bytes with din_valid held
        din = 8'hA5; din_valid = 1'b1;
        step();
        din = 8'h3C;
        clear_stats();
        repeat (NT) step();
        check("c_rdy_once", rdy_cnt, 1);
        din_valid = 1'b0;
        repeat (40) step();
        check("c_dv_cnt", dv_cnt, 2 * NT);
        check("c_dv_span", last_dv - first_dv + 1, 2 * NT);

        // tick every 5th cycle
        din = 8'($urandom); din_valid = 1'b1; sample_tick = 1'b0;
        step();
        din_valid = 1'b0;
        clear_stats();
        for (int i = 0; i < NT; i++) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            repeat (4) step();
        end
        repeat (8) step();
        check("d_dv_cnt", dv_cnt, NT);

        // ticks in IDLE
        sample_tick = 1'b1;
        repeat (10) step();

        // reset mid-byte at bit 3
        din = 8'($urandom); din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (3 * SPB + 1) step();
        async_reset();
        clear_stats();
        repeat (10) step();
        check("e_no_stale_dv", dv_cnt, 0);

        // 0xFF from phase 0: wrap at tick 31
        din = 8'hFF; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (30) step();
        check("b_addr_348", lut_addr, 348);
        step();
        check("b_addr_wrap", lut_addr, 0);
        repeat (12) step();

        for (int i = 0; i < 3000; i++) begin
            sample_tick = ($urandom_range(0, 3) != 0);
            din_valid   = ($urandom_range(0, 3) == 0);
            din         = 8'($urandom);
            if (i % 700 == 350) async_reset();
            else step();
        end
        sample_tick = 1'b0;
        din_valid = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
